// File: rtl/flow_meter_pkg.sv
// Shared flow-meter types: flow_rate width, ceiling and FSM encoding.
// Also used by the flow classifier for FLOW_W.
package flow_meter_pkg;

  localparam int FLOW_W   = 5;
  localparam int FLOW_MAX = 31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    PUBLISH = 2'd2
  } state_t;

endpackage

// File: rtl/flow_pulse_filter.sv
// Sensor input conditioning: 2-FF synchroniser, glitch filter and
// rising-edge detector on the filtered level.
module flow_pulse_filter #(
  parameter int FILTER_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_out,
  output logic rise_out
);

  localparam int CW =
    (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (sync2 != level_out) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt       <= '0;
      level_out <= 1'b0;
      rise_out  <= 1'b0;
    end else begin
      sync1    <= raw_in;
      sync2    <= sync1;
      rise_out <= flip & sync2;
      if (sync2 == level_out) begin
        cnt <= '0;
      end else if (flip) begin
        level_out <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/flow_pulse_meter.sv
// Hall-sensor flow meter: counts filtered pulses per gate window and
// publishes the scaled, saturated flow_rate with a one-cycle strobe.
module flow_pulse_meter
  import flow_meter_pkg::*;
#(
  parameter int GATE_CYCLES   = 1000,
  parameter int PULSE_SHIFT   = 0,
  parameter int FILTER_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sensor_in,
  output logic [FLOW_W-1:0] flow_rate,
  output logic              flow_valid,
  output logic              saturated
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  state_t           state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] pulse_cnt;
  logic [CNT_W-1:0] scaled;
  logic             over;
  logic             level;
  logic             rise;
  logic             pulse_evt;

  flow_pulse_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_in   (sensor_in),
    .level_out(level),
    .rise_out (rise)
  );

  assign pulse_evt = rise & level;
  assign scaled    = pulse_cnt >> PULSE_SHIFT;
  assign over      = scaled > CNT_W'(FLOW_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      pulse_cnt  <= '0;
      flow_rate  <= '0;
      flow_valid <= 1'b0;
      saturated  <= 1'b0;
    end else begin
      flow_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state     <= MEASURE;
            gate_cnt  <= '0;
            pulse_cnt <= '0;
          end
        end
        MEASURE: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            if (pulse_evt && (pulse_cnt != '1))
              pulse_cnt <= pulse_cnt + 1'b1;
            if (gate_cnt == GATE_LAST) begin
              gate_cnt <= '0;
              state    <= PUBLISH;
            end else begin
              gate_cnt <= gate_cnt + 1'b1;
            end
          end
        end
        PUBLISH: begin
          flow_rate  <= over ? FLOW_W'(FLOW_MAX)
                             : scaled[FLOW_W-1:0];
          saturated  <= over;
          flow_valid <= 1'b1;
          // a rise landing here opens the next window
          pulse_cnt  <= {{(CNT_W-1){1'b0}}, pulse_evt};
          gate_cnt   <= '0;
          state      <= enable ? MEASURE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
